fetch_pf: RTL and testbench

//  LC-3 instruction fetch unit with prefetch queue; parametrised successor to the single-shot fetch block.

---
 rtl/fetch_pf_pkg.sv | 30 +++
 rtl/fetch_pf_fifo.sv | 64 ++++++
 rtl/fetch_pf.sv | 160 ++++++++++++++++
 tb/tb_fetch_pf.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pf_pkg.sv
// Shared opcode constants, fetch FSM state encoding and redirect decode helper.
// Imported by the fetch unit and its queue.
package fetch_pf_pkg;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    // Whether a redirecting opcode actually changes the fetch stream.
    function automatic logic redir_hit(input logic [3:0] op,
                                       input logic [2:0] br_nzp,
                                       input logic [2:0] result_nzp);
        logic hit;
        hit = 1'b0;
        case (op)
            OP_BR:                   hit = |(br_nzp & result_nzp);
            OP_JMP, OP_JSR, OP_TRAP: hit = 1'b1;
            default:                 hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/fetch_pf_fifo.sv
// Prefetch queue: DEPTH-entry synchronous FIFO with flush and occupancy count.
// Latency: pushed entry visible at head the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty, flush wins over both.
module fetch_pf_fifo
    import fetch_pf_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    input  logic                       flush,
    output logic                       head_vld,
    output logic [W-1:0]               head_dat,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push  = push && (count != FULL_CNT);
    assign do_pop   = pop && (count != '0);
    assign head_vld = (count != '0);
    // Drive zero when empty so a flushed queue never shows stale entries.
    assign head_dat = head_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_pf.sv
// LC-3 fetch unit: streams sequential reads into a prefetch queue, redirects on BR/JMP/JSR/TRAP.
// Latency: instruction valid at decode one cycle after its mem_ack edge; zero-wait memory sustains 1/cycle.
// Backpressure: requests issued only while queue occupancy plus outstanding read stays below DEPTH.
module fetch_pf
    import fetch_pf_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fetch_en,
    output logic                       mem_req,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic                       mem_ack,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic                       wea_out,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [DATA_W-1:0]          inst_out,
    output logic [ADDR_W-1:0]          inst_pc,
    input  logic                       redir_valid,
    input  logic [3:0]                 redir_op,
    input  logic                       redir_mode,
    input  logic [10:0]                redir_off,
    input  logic [ADDR_W-1:0]          redir_base,
    input  logic [ADDR_W-1:0]          redir_reg,
    input  logic [2:0]                 br_nzp,
    input  logic [2:0]                 result_nzp,
    output logic                       redir_taken,
    output logic [ADDR_W-1:0]          pc,
    output logic [$clog2(DEPTH):0]     fill_level
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] inst;
    } q_entry_t;

    fetch_state_t      state;
    q_entry_t          push_ent;
    q_entry_t          head_ent;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] off9_sext;
    logic [ADDR_W-1:0] off11_sext;
    logic [ADDR_W-1:0] off8_zext;
    logic [CW-1:0]     cnt_after;
    logic              q_push;
    logic              q_pop;
    logic              idle_credit;
    logic              req_credit;

    assign wea_out = 1'b0;

    assign off9_sext  = {{(ADDR_W-9){redir_off[8]}}, redir_off[8:0]};
    assign off11_sext = {{(ADDR_W-11){redir_off[10]}}, redir_off[10:0]};
    assign off8_zext  = {{(ADDR_W-8){1'b0}}, redir_off[7:0]};

    always_comb begin
        target = pc;
        case (redir_op)
            OP_BR:   target = redir_base + off9_sext;
            OP_JMP:  target = redir_reg;
            OP_JSR:  target = redir_mode ? (redir_base + off11_sext) : redir_reg;
            OP_TRAP: target = off8_zext;
            default: target = pc;
        endcase
    end

    assign redir_taken = redir_valid && redir_hit(redir_op, br_nzp, result_nzp);

    assign pc_inc = pc + ADDR_W'(1);
    assign q_pop  = inst_ready && inst_valid;
    assign q_push = (state == ST_REQ) && mem_ack && !redir_taken;

    // Occupancy after this cycle's push/pop; the next request must still fit on top of it.
    assign cnt_after   = q_pop ? fill_level : (fill_level + CW'(1));
    assign idle_credit = (fill_level < DEPTH_C);
    assign req_credit  = (cnt_after < DEPTH_C);

    assign push_ent = '{pc: mem_addr, inst: mem_rdata};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC;
            pc       <= RESET_PC;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (redir_taken) begin
                        pc <= target;
                    end else if (fetch_en && idle_credit) begin
                        state    <= ST_REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= pc;
                    end
                end
                ST_REQ: begin
                    if (redir_taken) begin
                        pc <= target;
                        if (mem_ack) begin
                            state   <= ST_IDLE;
                            mem_req <= 1'b0;
                        end else begin
                            // Bus protocol forbids dropping the request; swallow its response instead.
                            state <= ST_DRAIN;
                        end
                    end else if (mem_ack) begin
                        pc <= pc_inc;
                        if (fetch_en && req_credit) begin
                            mem_addr <= pc_inc;
                        end else begin
                            state   <= ST_IDLE;
                            mem_req <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (redir_taken) begin
                        pc <= target;
                    end else if (mem_ack) begin
                        state   <= ST_IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    fetch_pf_fifo #(
        .W     (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .push     (q_push),
        .push_dat (push_ent),
        .pop      (q_pop),
        .flush    (redir_taken),
        .head_vld (inst_valid),
        .head_dat (head_ent),
        .count    (fill_level)
    );

    assign inst_out = head_ent.inst;
    assign inst_pc  = head_ent.pc;

endmodule

// File: tb/tb_fetch_pf.sv
// Directed bench for fetch_pf: streaming, queue-full credit, BR/TRAP/JMP/JSR redirects, PC wrap, async reset.
// Memory model returns addr ^ 16'hA5A5 after a programmable number of wait cycles.
module tb_fetch_pf;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        wea_out;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst_out;
    logic [15:0] inst_pc;
    logic        redir_valid;
    logic [3:0]  redir_op;
    logic        redir_mode;
    logic [10:0] redir_off;
    logic [15:0] redir_base;
    logic [15:0] redir_reg;
    logic [2:0]  br_nzp;
    logic [2:0]  result_nzp;
    logic        redir_taken;
    logic [15:0] pc;
    logic [2:0]  fill_level;

    int n_cmp;
    int n_err;
    int ack_delay;
    int wait_cnt;

    fetch_pf #(.ADDR_W(16), .DATA_W(16), .DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_en    (fetch_en),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .wea_out     (wea_out),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_out    (inst_out),
        .inst_pc     (inst_pc),
        .redir_valid (redir_valid),
        .redir_op    (redir_op),
        .redir_mode  (redir_mode),
        .redir_off   (redir_off),
        .redir_base  (redir_base),
        .redir_reg   (redir_reg),
        .br_nzp      (br_nzp),
        .result_nzp  (result_nzp),
        .redir_taken (redir_taken),
        .pc          (pc),
        .fill_level  (fill_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_ack   = mem_req && (wait_cnt >= ack_delay);
    assign mem_rdata = mem_addr ^ 16'hA5A5;

    always @(posedge clk) begin
        if (!mem_req || mem_ack) wait_cnt <= 0;
        else                     wait_cnt <= wait_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr_redir();
        redir_valid = 1'b0;
        redir_op    = 4'b0001;
        redir_mode  = 1'b0;
        redir_off   = '0;
        redir_base  = '0;
        redir_reg   = '0;
        br_nzp      = '0;
        result_nzp  = '0;
    endtask

    task automatic do_reset(input int n);
        rst        = 1'b1;
        fetch_en   = 1'b0;
        inst_ready = 1'b0;
        ack_delay  = 0;
        clr_redir();
        tick(n);
        rst = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        wait_cnt  = 0;
        rst       = 1'b0;
        fetch_en  = 1'b0;
        inst_ready = 1'b0;
        ack_delay = 0;
        clr_redir();
        #2;

        // Reset state, then zero-wait streaming
        do_reset(5);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0000);
        chk("rst_pc", 32'(pc), 32'h0000);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst_out", 32'(inst_out), 32'h0000);
        chk("rst_inst_pc", 32'(inst_pc), 32'h0000);
        chk("rst_fill", 32'(fill_level), 32'd0);
        chk("rst_wea", 32'(wea_out), 32'd0);
        fetch_en   = 1'b1;
        inst_ready = 1'b1;
        tick(1);
        chk("s1_req0", 32'(mem_req), 32'd1);
        chk("s1_addr0", 32'(mem_addr), 32'h0000);
        tick(1);
        chk("s1_addr1", 32'(mem_addr), 32'h0001);
        chk("s1_valid0", 32'(inst_valid), 32'd1);
        chk("s1_ipc0", 32'(inst_pc), 32'h0000);
        chk("s1_inst0", 32'(inst_out), 32'hA5A5);
        tick(1);
        chk("s1_addr2", 32'(mem_addr), 32'h0002);
        chk("s1_ipc1", 32'(inst_pc), 32'h0001);
        chk("s1_inst1", 32'(inst_out), 32'hA5A4);
        tick(1);
        chk("s1_addr3", 32'(mem_addr), 32'h0003);
        chk("s1_ipc2", 32'(inst_pc), 32'h0002);

        // Queue full with decode stalled, then a single pop releases one credit
        do_reset(2);
        fetch_en = 1'b1;
        tick(5);
        chk("s2_fill4", 32'(fill_level), 32'd4);
        chk("s2_req_off", 32'(mem_req), 32'd0);
        chk("s2_head_pc", 32'(inst_pc), 32'h0000);
        tick(1);
        chk("s2_still_off", 32'(mem_req), 32'd0);
        inst_ready = 1'b1;
        tick(1);
        inst_ready = 1'b0;
        chk("s2_fill3", 32'(fill_level), 32'd3);
        chk("s2_head_pc1", 32'(inst_pc), 32'h0001);
        chk("s2_no_req_yet", 32'(mem_req), 32'd0);
        tick(1);
        chk("s2_req_again", 32'(mem_req), 32'd1);
        chk("s2_addr4", 32'(mem_addr), 32'h0004);
        tick(1);
        chk("s2_refull", 32'(fill_level), 32'd4);
        chk("s2_req_off2", 32'(mem_req), 32'd0);

        // Taken BR: 0x0010 + sext(0x1FE) = 0x000E
        do_reset(2);
        fetch_en   = 1'b1;
        inst_ready = 1'b1;
        tick(2);
        redir_valid = 1'b1;
        redir_op    = 4'b0000;
        redir_base  = 16'h0010;
        redir_off   = 11'h1FE;
        br_nzp      = 3'b010;
        result_nzp  = 3'b010;
        #1;
        chk("s3_br_taken", 32'(redir_taken), 32'd1);
        tick(1);
        clr_redir();
        chk("s3_flush_fill", 32'(fill_level), 32'd0);
        chk("s3_flush_valid", 32'(inst_valid), 32'd0);
        chk("s3_pc_tgt", 32'(pc), 32'h000E);
        chk("s3_idle", 32'(mem_req), 32'd0);
        tick(1);
        chk("s3_addr_tgt", 32'(mem_addr), 32'h000E);
        tick(1);
        chk("s3_ipc_tgt", 32'(inst_pc), 32'h000E);
        // Untaken BR: condition codes disagree
        redir_valid = 1'b1;
        redir_op    = 4'b0000;
        redir_base  = 16'h0010;
        redir_off   = 11'h1FE;
        br_nzp      = 3'b010;
        result_nzp  = 3'b100;
        #1;
        chk("s3_br_untaken", 32'(redir_taken), 32'd0);
        tick(1);
        clr_redir();
        chk("s3_stream_addr", 32'(mem_addr), 32'h0010);
        chk("s3_stream_ipc", 32'(inst_pc), 32'h000F);

        // TRAP while a slow read is pending: request held, response dropped
        ack_delay   = 3;
        redir_valid = 1'b1;
        redir_op    = 4'b1111;
        redir_off   = 11'h025;
        #1;
        chk("s4_trap_taken", 32'(redir_taken), 32'd1);
        tick(1);
        clr_redir();
        chk("s4_drain_req", 32'(mem_req), 32'd1);
        chk("s4_drain_addr", 32'(mem_addr), 32'h0010);
        chk("s4_drain_fill", 32'(fill_level), 32'd0);
        chk("s4_pc_tgt", 32'(pc), 32'h0025);
        tick(2);
        chk("s4_hold_addr", 32'(mem_addr), 32'h0010);
        chk("s4_ack_now", 32'(mem_ack), 32'd1);
        tick(1);
        chk("s4_dropped_req", 32'(mem_req), 32'd0);
        chk("s4_dropped_valid", 32'(inst_valid), 32'd0);
        tick(1);
        chk("s4_trap_req", 32'(mem_req), 32'd1);
        chk("s4_trap_addr", 32'(mem_addr), 32'h0025);
        ack_delay = 0;

        // JMP to 0xFFFF then PC wrap; JSR PC-relative 0x3000 + sext(0x400) = 0x2C00
        do_reset(2);
        fetch_en    = 1'b1;
        inst_ready  = 1'b1;
        redir_valid = 1'b1;
        redir_op    = 4'b1100;
        redir_reg   = 16'hFFFF;
        tick(1);
        clr_redir();
        chk("s5_jmp_pc", 32'(pc), 32'hFFFF);
        tick(1);
        chk("s5_addr_ffff", 32'(mem_addr), 32'hFFFF);
        tick(1);
        chk("s5_addr_wrap", 32'(mem_addr), 32'h0000);
        chk("s5_ipc_ffff", 32'(inst_pc), 32'hFFFF);
        redir_valid = 1'b1;
        redir_op    = 4'b0100;
        redir_mode  = 1'b1;
        redir_base  = 16'h3000;
        redir_off   = 11'h400;
        redir_reg   = 16'h1234;
        tick(1);
        clr_redir();
        chk("s5_jsr_pc", 32'(pc), 32'h2C00);
        tick(1);
        chk("s5_jsr_addr", 32'(mem_addr), 32'h2C00);
        redir_valid = 1'b1;
        redir_op    = 4'b0001;
        #1;
        chk("s5_other_op", 32'(redir_taken), 32'd0);
        clr_redir();

        // Asynchronous reset in the middle of a request
        ack_delay = 3;
        tick(2);
        chk("s6_pre_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("s6_req_clr", 32'(mem_req), 32'd0);
        chk("s6_pc_clr", 32'(pc), 32'h0000);
        chk("s6_valid_clr", 32'(inst_valid), 32'd0);
        chk("s6_fill_clr", 32'(fill_level), 32'd0);
        chk("s6_wea", 32'(wea_out), 32'd0);
        tick(2);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
